// File: rtl/alu16_seq_pkg.sv
// Shared types and constants for the 16-bit ALU sequencer.
// Covers ALU op codes, flag bit positions, op16 and FSM encodings, and the latched request payload.
package alu16_seq_pkg;

  localparam int unsigned ALU_OP_W_DEF = 5;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_ADC = 5'b00001;
  localparam logic [4:0] OP_SUB = 5'b00010;
  localparam logic [4:0] OP_SBC = 5'b00011;

  localparam int unsigned F_Z = 3;
  localparam int unsigned F_N = 2;
  localparam int unsigned F_H = 1;
  localparam int unsigned F_C = 0;

  typedef enum logic [1:0] {
    OP16_ADD_HL    = 2'b00,
    OP16_ADD_SP_E8 = 2'b01,
    OP16_INC       = 2'b10,
    OP16_DEC       = 2'b11
  } op16_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LO   = 2'b01,
    S_HI   = 2'b10,
    S_DONE = 2'b11
  } state_t;

  // Operands captured when a request is accepted
  typedef struct packed {
    op16_t       op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  f;
  } req_t;

endpackage

// File: rtl/alu16_seq_if.sv
// Request/response and ALU-side signals of the 16-bit sequencer.
// The slave modport is the sequencer; master is the parent that owns the regfile and the 8-bit ALU.
interface alu16_seq_if
  import alu16_seq_pkg::*;
#(
  parameter int unsigned ALU_OP_W = ALU_OP_W_DEF
) ();

  logic                start;
  op16_t               op16;
  logic [15:0]         opa;
  logic [15:0]         opb;
  logic [3:0]          flags_in;
  logic                busy;
  logic                done;
  logic [15:0]         result;
  logic [3:0]          flags_out;
  logic [7:0]          alu_a;
  logic [7:0]          alu_b;
  logic [ALU_OP_W-1:0] alu_op;
  logic [3:0]          alu_flags;
  logic [7:0]          alu_result;
  logic [3:0]          alu_flags_r;

  modport slave (
    input  start, op16, opa, opb, flags_in, alu_result, alu_flags_r,
    output busy, done, result, flags_out, alu_a, alu_b, alu_op, alu_flags
  );

  modport master (
    output start, op16, opa, opb, flags_in, alu_result, alu_flags_r,
    input  busy, done, result, flags_out, alu_a, alu_b, alu_op, alu_flags
  );

endinterface

// File: rtl/alu16_seq.sv
// Two-pass 16-bit sequencer (ADD HL,rr / ADD SP,e8 / INC rr / DEC rr) over a shared 8-bit ALU.
// Optional build macro ALU16_FAST_INCDEC_EN: INC16/DEC16 bypass the ALU and finish one cycle after start.
module alu16_seq
  import alu16_seq_pkg::*;
#(
  parameter int unsigned ALU_OP_W     = ALU_OP_W_DEF,
  parameter bit          SP_FLAGS_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  alu16_seq_if.slave bus
);

  state_t              state, state_d;
  req_t                req_q, src;
  logic                accept, fast_op;
  logic [15:0]         fast_res;
  logic [7:0]          lo_q;
  logic                c_lo_q, h_lo_q;
  logic                busy_q, busy_d, done_q, done_d;
  logic [15:0]         result_q, result_d;
  logic [3:0]          flags_q, flags_d;
  logic [7:0]          alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;
  logic [3:0]          alu_flags_q, alu_flags_d;
  logic                unused_ok;

  assign accept    = (state == S_IDLE) && bus.start;
  assign src       = accept ? '{op: bus.op16, a: bus.opa, b: bus.opb, f: bus.flags_in} : req_q;
  assign unused_ok = ^bus.alu_flags_r[F_Z:F_N];

`ifdef ALU16_FAST_INCDEC_EN
  assign fast_op  = (bus.op16 == OP16_INC) || (bus.op16 == OP16_DEC);
  assign fast_res = (bus.op16 == OP16_INC) ? bus.opa + 16'd1 : bus.opa - 16'd1;
`else
  assign fast_op  = 1'b0;
  assign fast_res = '0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (bus.start) state_d = fast_op ? S_DONE : S_LO;
      S_LO:    state_d = S_HI;
      S_HI:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the state being entered; ALU drive is registered so it is valid throughout that state
  always_comb begin
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    result_d    = result_q;
    flags_d     = flags_q;
    alu_a_d     = '0;
    alu_b_d     = '0;
    alu_op_d    = ALU_OP_W'(OP_ADD);
    alu_flags_d = '0;
    case (state_d)
      S_LO: begin
        alu_a_d     = src.a[7:0];
        alu_flags_d = {src.f[F_Z:F_H], 1'b0};
        alu_b_d     = (src.op == OP16_ADD_HL || src.op == OP16_ADD_SP_E8) ? src.b[7:0] : 8'h01;
        if (src.op == OP16_DEC) alu_op_d = ALU_OP_W'(OP_SUB);
      end
      S_HI: begin
        // Entered from LO, so the ALU carry output is the low-byte carry/borrow right now
        alu_a_d     = req_q.a[15:8];
        alu_flags_d = {req_q.f[F_Z:F_H], bus.alu_flags_r[F_C]};
        alu_op_d    = (req_q.op == OP16_DEC) ? ALU_OP_W'(OP_SBC) : ALU_OP_W'(OP_ADC);
        case (req_q.op)
          OP16_ADD_HL:    alu_b_d = req_q.b[15:8];
          OP16_ADD_SP_E8: alu_b_d = {8{req_q.b[7]}};
          default:        alu_b_d = 8'h00;
        endcase
      end
      S_DONE: begin
        if (accept) begin
          result_d = fast_res;
          flags_d  = bus.flags_in;
        end else if (state == S_HI) begin
          result_d = {bus.alu_result, lo_q};
          case (req_q.op)
            OP16_ADD_HL:
              flags_d = {req_q.f[F_Z], 1'b0, bus.alu_flags_r[F_H], bus.alu_flags_r[F_C]};
            OP16_ADD_SP_E8:
              flags_d = SP_FLAGS_LOW ? {2'b00, h_lo_q, c_lo_q}
                                     : {2'b00, bus.alu_flags_r[F_H], bus.alu_flags_r[F_C]};
            default:
              flags_d = req_q.f;
          endcase
        end
      end
      default: ;
    endcase
  end

  // Operand latch, low-byte capture and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q       <= '0;
      lo_q        <= '0;
      c_lo_q      <= 1'b0;
      h_lo_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= ALU_OP_W'(OP_ADD);
      alu_flags_q <= '0;
    end else begin
      if (accept) req_q <= src;
      if (state == S_LO) begin
        lo_q   <= bus.alu_result;
        c_lo_q <= bus.alu_flags_r[F_C];
        h_lo_q <= bus.alu_flags_r[F_H];
      end
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      alu_flags_q <= alu_flags_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.flags_out = flags_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.alu_flags = alu_flags_q;

endmodule

// File: tb/tb_alu16_seq.sv
// Bench for alu16_seq: behavioural 8-bit ALU beside the DUT, 16-bit reference model, directed and random ops.
module tb_alu16_seq;
  import alu16_seq_pkg::*;

  localparam bit SP_LOW = 1'b1;
`ifdef ALU16_FAST_INCDEC_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  alu16_seq_if #(.ALU_OP_W(5)) bus ();

  alu16_seq #(.ALU_OP_W(5), .SP_FLAGS_LOW(SP_LOW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // 8-bit ALU: add/sub with optional carry/borrow in, H from bit 3, C from bit 7
  int         t_cin, t_sum, t_hs;
  logic [7:0] t_res;
  always_comb begin
    t_cin = (bus.alu_op == 5'd1 || bus.alu_op == 5'd3) ? int'(bus.alu_flags[0]) : 0;
    if (bus.alu_op == 5'd0 || bus.alu_op == 5'd1) begin
      t_sum = int'(bus.alu_a) + int'(bus.alu_b) + t_cin;
      t_hs  = int'(bus.alu_a[3:0]) + int'(bus.alu_b[3:0]) + t_cin;
      t_res = t_sum[7:0];
      bus.alu_flags_r = {t_res == 8'h00, 1'b0, t_hs > 15, t_sum > 255};
    end else begin
      t_sum = int'(bus.alu_a) - int'(bus.alu_b) - t_cin;
      t_hs  = int'(bus.alu_a[3:0]) - int'(bus.alu_b[3:0]) - t_cin;
      t_res = t_sum[7:0];
      bus.alu_flags_r = {t_res == 8'h00, 1'b1, t_hs < 0, t_sum < 0};
    end
    bus.alu_result = t_res;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Whole-word reference for each 16-bit op
  function automatic void model(input op16_t op, input logic [15:0] a, input logic [15:0] b,
                                input logic [3:0] f, output logic [15:0] r, output logic [3:0] fo);
    int s, e, sx;
    case (op)
      OP16_ADD_HL: begin
        s  = int'(a) + int'(b);
        r  = 16'(s);
        fo = {f[3], 1'b0, (int'(a[11:0]) + int'(b[11:0])) > 4095, s > 65535};
      end
      OP16_ADD_SP_E8: begin
        e = int'(b[7:0]);
        if (e > 127) e = e - 256;
        r  = 16'(int'(a) + e);
        sx = int'({{8{b[7]}}, b[7:0]});
        if (SP_LOW)
          fo = {2'b00, (int'(a[3:0]) + int'(b[3:0])) > 15, (int'(a[7:0]) + int'(b[7:0])) > 255};
        else
          fo = {2'b00, (int'(a[11:0]) + (sx % 4096)) > 4095, (int'(a) + sx) > 65535};
      end
      OP16_INC: begin r = 16'(int'(a) + 1); fo = f; end
      default:  begin r = 16'(int'(a) - 1); fo = f; end
    endcase
  endfunction

  task automatic run_op(input op16_t op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] f, input bit repulse);
    logic [15:0] er;
    logic [3:0]  ef;
    int          k, lat, ndone;
    model(op, a, b, f, er, ef);
    lat = (FAST && (op == OP16_INC || op == OP16_DEC)) ? 1 : 3;
    bus.start = 1'b1; bus.op16 = op; bus.opa = a; bus.opb = b; bus.flags_in = f;
    @(posedge clk); #1;
    bus.start    = repulse;
    bus.opa      = 16'($urandom);
    bus.opb      = 16'($urandom);
    bus.flags_in = 4'($urandom);
    bus.op16     = op16_t'(2'($urandom_range(3)));
    k = 1;
    if (lat == 3) begin
      chk("lo_alu_a", bus.alu_a, a[7:0]);
      chk("lo_alu_op", bus.alu_op, (op == OP16_DEC) ? 5'd2 : 5'd0);
    end
    while (!bus.done && k < 8) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      k++;
    end
    bus.start = 1'b0;
    chk("latency", k, lat);
    chk("done", bus.done, 1'b1);
    chk("result", bus.result, er);
    chk("flags", bus.flags_out, ef);
    ndone = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    chk("extra_done", ndone, 0);
    chk("idle_busy", bus.busy, 1'b0);
  endtask

  initial begin
    int ndone;
    rst = 1'b1;
    bus.start = 1'b0; bus.op16 = OP16_ADD_HL; bus.opa = '0; bus.opb = '0; bus.flags_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_result", bus.result, 16'h0000);
    chk("rst_flags", bus.flags_out, 4'h0);
    chk("rst_alu_a", bus.alu_a, 8'h00);
    chk("rst_alu_b", bus.alu_b, 8'h00);
    chk("rst_alu_op", bus.alu_op, 5'd0);
    chk("rst_alu_flags", bus.alu_flags, 4'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(OP16_ADD_HL, 16'h0FFF, 16'h0001, 4'b1000, 1'b0);
    chk("v1_result", bus.result, 16'h1000);
    chk("v1_flags", bus.flags_out, 4'b1010);
    run_op(OP16_ADD_SP_E8, 16'hFFF8, 16'h0008, 4'b1111, 1'b0);
    chk("v2_result", bus.result, 16'h0000);
    chk("v2_flags", bus.flags_out, 4'b0011);
    run_op(OP16_ADD_SP_E8, 16'h0000, 16'h00FF, 4'b0000, 1'b0);
    chk("v3_result", bus.result, 16'hFFFF);
    chk("v3_flags", bus.flags_out, 4'b0000);
    run_op(OP16_DEC, 16'h0000, 16'h0000, 4'b1010, 1'b0);
    chk("v4_result", bus.result, 16'hFFFF);
    chk("v4_flags", bus.flags_out, 4'b1010);
    run_op(OP16_INC, 16'hFFFF, 16'h5555, 4'b0101, 1'b0);
    chk("v5_result", bus.result, 16'h0000);
    chk("v5_flags", bus.flags_out, 4'b0101);
    run_op(OP16_INC, 16'h12FF, 16'h0000, 4'b0000, 1'b0);
    chk("v6_result", bus.result, 16'h1300);

    // Start re-pulsed during LO must not queue a second op
    run_op(OP16_ADD_HL, 16'h1234, 16'h1111, 4'b1000, 1'b1);
    chk("v7_result", bus.result, 16'h2345);

    // Reset while in HI
    bus.start = 1'b1; bus.op16 = OP16_ADD_HL; bus.opa = 16'h4321; bus.opb = 16'h0101; bus.flags_in = 4'b1000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_busy", bus.busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_result", bus.result, 16'h0000);
    chk("midrst_flags", bus.flags_out, 4'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    ndone = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    chk("midrst_no_done", ndone, 0);

    repeat (40) begin
      run_op(op16_t'(2'($urandom_range(3))), 16'($urandom), 16'($urandom), 4'($urandom),
             1'($urandom_range(1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
